key_event_decoder: RTL and testbench



---
 rtl/key_evt_pkg.sv | 28 ++
 rtl/key_release_filter.sv | 60 ++++++
 rtl/key_event_decoder.sv | 191 +++++++++++++++++++
 tb/tb_key_event_decoder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
`default_nettype none
//============================================================================
// Module      : key_evt_pkg
// Description : Shared definitions for the key event decoder: the classifier
//               state encoding and the default timing constants (cycle counts
//               at a 100 MHz clock).
// Revision    : 1.0  initial release
//============================================================================
package key_evt_pkg;

    // Classifier states, explicitly 3-bit encoded.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } key_state_t;

    // Default counter width and timing (cycles at 100 MHz).
    localparam int unsigned c_cnt_width   = 27;
    localparam logic [26:0] c_long_max    = 27'd99_999_999; // 1 s hold
    localparam logic [26:0] c_dbl_win_max = 27'd24_999_999; // 250 ms gap
    localparam logic [26:0] c_rel_max     = 27'd1_999_999;  // 20 ms low
    localparam logic [26:0] c_repeat_max  = 27'd19_999_999; // 200 ms repeat

endpackage : key_evt_pkg
`default_nettype wire

// File: rtl/key_release_filter.sv
`default_nettype none
//============================================================================
// Module      : key_release_filter
// Description : Detects a genuine key release. Produces a one-cycle rel_done
//               pulse in the cycle where key_in has been low for REL_MAX+1
//               consecutive cycles. The low-run counter clears whenever
//               key_in is high and stops after firing, so one release gives
//               exactly one pulse.
// Ports       : clk      in  system clock (rising edge)
//               rst_n    in  asynchronous active-low reset
//               key_in   in  raw key level, active-high
//               rel_done out one-cycle release pulse
// Parameters  : CNT_WIDTH width of the low-run counter
//               REL_MAX   low cycles (minus one) that qualify a release
// Revision    : 1.0  initial release
//============================================================================
module key_release_filter
    import key_evt_pkg::*;
#(
    parameter int unsigned          CNT_WIDTH = c_cnt_width,
    parameter logic [CNT_WIDTH-1:0] REL_MAX   = CNT_WIDTH'(c_rel_max)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic rel_done
);

    logic [CNT_WIDTH-1:0] r_low_cnt;
    logic                 r_fired;
    logic                 w_hit;

    // key_in is the same level that feeds the upstream debouncer and is
    // assumed to be already synchronous to clk. The pulse is decoded
    // combinationally so it lines up with the qualifying low cycle; the
    // consumer registers everything derived from it.
    assign w_hit    = !key_in && !r_fired && (r_low_cnt == REL_MAX);
    assign rel_done = w_hit;

    // The counter parks at REL_MAX and r_fired blocks further pulses, so the
    // count can never wrap even when REL_MAX is the largest encodable value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low_cnt <= '0;
            r_fired   <= 1'b0;
        end else if (key_in) begin
            r_low_cnt <= '0;
            r_fired   <= 1'b0;
        end else begin
            if (r_low_cnt != REL_MAX) begin
                r_low_cnt <= r_low_cnt + 1'b1;
            end
            if (w_hit) begin
                r_fired <= 1'b1;
            end
        end
    end

endmodule : key_release_filter
`default_nettype wire

// File: rtl/key_event_decoder.sv
`default_nettype none
//============================================================================
// Module      : key_event_decoder
// Description : Classifies debounced key presses into single click, double
//               click and long press events, with optional auto-repeat while
//               the key stays held after a long press.
// Ports       : clk          in  system clock (rising edge)
//               rst_n        in  asynchronous active-low reset
//               key_flag     in  one-cycle press pulse from the debouncer
//               key_in       in  raw key level, active-high
//               single_click out one-cycle pulse, single click
//               double_click out one-cycle pulse, double click
//               long_press   out one-cycle pulse, hold reached LONG_MAX
//               long_repeat  out one-cycle pulse per REPEAT_MAX while held
//               busy         out high whenever the classifier is not idle
// Macro       : KEY_REPEAT_EN - when defined, LONG_HOLD emits long_repeat
//               every REPEAT_MAX cycles; otherwise long_repeat stays 0.
// Revision    : 1.0  initial release
//============================================================================
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter int unsigned          CNT_WIDTH   = c_cnt_width,
    parameter logic [CNT_WIDTH-1:0] LONG_MAX    = CNT_WIDTH'(c_long_max),
    parameter logic [CNT_WIDTH-1:0] DBL_WIN_MAX = CNT_WIDTH'(c_dbl_win_max),
    parameter logic [CNT_WIDTH-1:0] REL_MAX     = CNT_WIDTH'(c_rel_max),
    parameter logic [CNT_WIDTH-1:0] REPEAT_MAX  = CNT_WIDTH'(c_repeat_max)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_flag,
    input  logic key_in,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic long_repeat,
    output logic busy
);

`ifdef KEY_REPEAT_EN
    localparam bit c_repeat_en = 1'b1;
`else
    localparam bit c_repeat_en = 1'b0;
`endif

    // Terminal counts: the transition decision is taken one cycle before the
    // registered event appears, hence the "minus one" forms.
    localparam logic [CNT_WIDTH-1:0] c_long_last   = LONG_MAX - 1'b1;
    localparam logic [CNT_WIDTH-1:0] c_repeat_last = REPEAT_MAX - 1'b1;

    key_state_t           r_state;
    key_state_t           w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 w_rel_done;

    logic w_single;
    logic w_double;
    logic w_long;
    logic w_repeat;

    logic r_single;
    logic r_double;
    logic r_long;
    logic r_repeat;
    logic r_busy;

    //------------------------------------------------------------------------
    // Release qualification
    //------------------------------------------------------------------------
    key_release_filter #(
        .CNT_WIDTH (CNT_WIDTH),
        .REL_MAX   (REL_MAX)
    ) u_rel_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .rel_done (w_rel_done)
    );

    // Saturating increment shared by all counting states.
    assign w_cnt_inc = (r_cnt == {CNT_WIDTH{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    //------------------------------------------------------------------------
    // Next state, next count and event decode
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_single    = 1'b0;
        w_double    = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;

        case (r_state)
            IDLE: begin
                if (key_flag) begin
                    w_state_nxt = PRESS1;
                end
            end

            // Release takes priority over the long-press threshold.
            PRESS1: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_rel_done) begin
                    w_state_nxt = WAIT2;
                end else if (r_cnt == c_long_last) begin
                    w_state_nxt = LONG_HOLD;
                    w_long      = 1'b1;
                end
            end

            // A second press in the last window cycle still counts as double.
            WAIT2: begin
                w_cnt_nxt = w_cnt_inc;
                if (key_flag) begin
                    w_state_nxt = PRESS2;
                    w_double    = 1'b1;
                end else if (r_cnt == DBL_WIN_MAX) begin
                    w_state_nxt = IDLE;
                    w_single    = 1'b1;
                end
            end

            // Second press of a double click: no long detection here.
            PRESS2: begin
                w_cnt_nxt = '0;
                if (w_rel_done) begin
                    w_state_nxt = IDLE;
                end
            end

            LONG_HOLD: begin
                if (w_rel_done) begin
                    w_state_nxt = IDLE;
                end else if (c_repeat_en) begin
                    if (r_cnt == c_repeat_last) begin
                        w_cnt_nxt = '0;
                        w_repeat  = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Every state change starts the next phase from a zero count.
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end
    end

    //------------------------------------------------------------------------
    // State, counter and registered outputs
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_single <= w_single;
            r_double <= w_double;
            r_long   <= w_long;
            r_repeat <= w_repeat;
            // Registered from the next state so busy tracks r_state exactly.
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

    assign single_click = r_single;
    assign double_click = r_double;
    assign long_press   = r_long;
    assign long_repeat  = r_repeat;
    assign busy         = r_busy;

endmodule : key_event_decoder
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
//============================================================================
// Module      : tb_key_event_decoder
// Description : Self-checking bench for key_event_decoder with shortened
//               timing (LONG_MAX=100, DBL_WIN_MAX=50, REL_MAX=4,
//               REPEAT_MAX=20). Expected events are queued with the cycle
//               they must appear in; a monitor pops and compares every pulse.
// Macro       : KEY_REPEAT_EN - selects whether auto-repeat pulses are expected
// Revision    : 1.0  initial release
//============================================================================
module tb_key_event_decoder;

    localparam int c_long_max   = 100;
    localparam int c_dbl_max    = 50;
    localparam int c_rel_max    = 4;
    localparam int c_repeat_max = 20;

    localparam logic [3:0] c_ev_single = 4'b1000;
    localparam logic [3:0] c_ev_double = 4'b0100;
    localparam logic [3:0] c_ev_long   = 4'b0010;
    localparam logic [3:0] c_ev_repeat = 4'b0001;

    typedef struct {
        int         cyc;
        logic [3:0] evt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic key_flag;
    logic key_in;
    logic single_click;
    logic double_click;
    logic long_press;
    logic long_repeat;
    logic busy;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    key_event_decoder #(
        .CNT_WIDTH   (27),
        .LONG_MAX    (27'd100),
        .DBL_WIN_MAX (27'd50),
        .REL_MAX     (27'd4),
        .REPEAT_MAX  (27'd20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_flag     (key_flag),
        .key_in       (key_in),
        .single_click (single_click),
        .double_click (double_click),
        .long_press   (long_press),
        .long_repeat  (long_repeat),
        .busy         (busy)
    );

    // One cycle: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic at(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_evt(input int c, input logic [3:0] ev);
        exp_t e;
        e.cyc = c;
        e.evt = ev;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_drained(input string tag);
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL %s missing_events observed=%0d expected=0", tag, sb.size());
        end
        sb.delete();
    endtask

    // Every event pulse must match the head of the scoreboard in kind and cycle.
    always @(negedge clk) begin : mon
        logic [3:0] ev;
        exp_t       e;
        ev = {single_click, double_click, long_press, long_repeat};
        if (ev !== 4'b0000) begin
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_event cyc=%0d observed=%b expected=none", cyc, ev);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert (ev === e.evt && cyc == e.cyc) else begin
                    failures++;
                    $error("FAIL event observed=%b@%0d expected=%b@%0d", ev, cyc, e.evt, e.cyc);
                end
            end
        end
    end

    initial begin
        int t0;
        int first_low;
        int rel;
        int w2;

        rst_n    = 1'b0;
        key_flag = 1'b0;
        key_in   = 1'b0;
        tick();
        tick();
        check("rst_single", single_click, 1'b0);
        check("rst_double", double_click, 1'b0);
        check("rst_long",   long_press,   1'b0);
        check("rst_repeat", long_repeat,  1'b0);
        check("rst_busy",   busy,         1'b0);
        rst_n = 1'b1;
        at(10);

        // ---- Single click: press 10..30, release filtered at 35 ----------
        t0 = cyc;
        first_low = t0 + 31;
        rel = first_low + c_rel_max;
        w2  = rel + 1;
        at(t0 + 10);
        key_flag = 1'b1;
        key_in   = 1'b1;
        expect_evt(w2 + c_dbl_max + 1, c_ev_single);
        tick();
        key_flag = 1'b0;
        check("single_busy_press1", busy, 1'b1);
        at(first_low);
        key_in = 1'b0;
        at(w2 + c_dbl_max);
        check("single_busy_wait2", busy, 1'b1);
        at(w2 + c_dbl_max + 1);
        check("single_busy_idle", busy, 1'b0);
        at(w2 + c_dbl_max + 10);
        check_drained("single");

        // ---- Double click: second flag 20 cycles into WAIT2 --------------
        t0 = cyc;
        first_low = t0 + 31;
        w2 = first_low + c_rel_max + 1;
        at(t0 + 10);
        key_flag = 1'b1;
        key_in   = 1'b1;
        tick();
        key_flag = 1'b0;
        at(first_low);
        key_in = 1'b0;
        at(w2 + 20);
        key_flag = 1'b1;
        key_in   = 1'b1;
        expect_evt(w2 + 21, c_ev_double);
        tick();
        key_flag = 1'b0;
        at(w2 + 30);
        key_in = 1'b0;
        rel = w2 + 30 + c_rel_max;
        at(rel);
        check("double_busy_press2", busy, 1'b1);
        at(rel + 1);
        check("double_busy_idle", busy, 1'b0);
        at(w2 + c_dbl_max + 20);
        check_drained("double");

        // ---- Long press: key held 300 cycles ------------------------------
        t0 = cyc;
        first_low = t0 + 310;
        rel = first_low + c_rel_max;
        at(t0 + 10);
        key_flag = 1'b1;
        key_in   = 1'b1;
        expect_evt(t0 + 11 + c_long_max, c_ev_long);
`ifdef KEY_REPEAT_EN
        for (int c = t0 + 11 + c_long_max + c_repeat_max; c <= rel; c += c_repeat_max) begin
            expect_evt(c, c_ev_repeat);
        end
`endif
        tick();
        key_flag = 1'b0;
        at(t0 + 200);
        check("long_busy_hold", busy, 1'b1);
        key_flag = 1'b1;  // ignored while held
        tick();
        key_flag = 1'b0;
        at(first_low);
        key_in = 1'b0;
        at(rel + 1);
        check("long_busy_idle", busy, 1'b0);
        at(rel + 10);
        check_drained("long");

        // ---- Second press exactly at window end -> double only ------------
        t0 = cyc;
        first_low = t0 + 31;
        w2 = first_low + c_rel_max + 1;
        at(t0 + 10);
        key_flag = 1'b1;
        key_in   = 1'b1;
        tick();
        key_flag = 1'b0;
        at(first_low);
        key_in = 1'b0;
        at(w2 + c_dbl_max);
        key_flag = 1'b1;
        key_in   = 1'b1;
        expect_evt(w2 + c_dbl_max + 1, c_ev_double);
        tick();
        key_flag = 1'b0;
        at(w2 + c_dbl_max + 5);
        key_in = 1'b0;
        at(w2 + c_dbl_max + 5 + c_rel_max + 1);
        check("edge_busy_idle", busy, 1'b0);
        at(w2 + 2 * c_dbl_max + 20);
        check_drained("window_edge");

        // ---- 3-cycle glitch during PRESS1 is not a release ----------------
        t0 = cyc;
        first_low = t0 + 31;
        w2 = first_low + c_rel_max + 1;
        at(t0 + 10);
        key_flag = 1'b1;
        key_in   = 1'b1;
        expect_evt(w2 + c_dbl_max + 1, c_ev_single);
        tick();
        key_flag = 1'b0;
        at(t0 + 15);
        key_in = 1'b0;
        at(t0 + 18);
        key_in = 1'b1;
        at(t0 + 25);
        check("glitch_busy_press1", busy, 1'b1);
        at(first_low);
        key_in = 1'b0;
        at(w2 + c_dbl_max + 10);
        check_drained("glitch");

        // ---- Reset mid-PRESS1, then first flag after reset ----------------
        t0 = cyc;
        at(t0 + 10);
        key_flag = 1'b1;
        key_in   = 1'b1;
        tick();
        key_flag = 1'b0;
        at(t0 + 20);
        check("midrst_busy_before", busy, 1'b1);
        rst_n  = 1'b0;
        key_in = 1'b0;
        #1;
        check("midrst_busy",   busy,         1'b0);
        check("midrst_single", single_click, 1'b0);
        check("midrst_long",   long_press,   1'b0);
        at(t0 + 24);
        rst_n = 1'b1;
        tick();
        key_flag = 1'b1;
        key_in   = 1'b1;
        first_low = t0 + 35;
        w2 = first_low + c_rel_max + 1;
        expect_evt(w2 + c_dbl_max + 1, c_ev_single);
        tick();
        key_flag = 1'b0;
        check("postrst_busy", busy, 1'b1);
        at(first_low);
        key_in = 1'b0;
        at(w2 + c_dbl_max + 10);
        check_drained("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_key_event_decoder
`default_nettype wire
